// File: rtl/card_dealer.sv
// Card dealer: draws a rank from a free-running count (mod 13, bit-serial) and deals
// from a 52-card deck, skipping forward over exhausted ranks.
module card_dealer #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned COPIES = 4
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Count,
    input  logic             i_Draw,
    input  logic             i_Shuffle,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Value,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Empty,
    output logic [5:0]       o_Remaining
);

    localparam int unsigned NRANK = 13;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned BIT_W = $clog2(WIDTH + 1);
    localparam int unsigned REM_W = 6;
    localparam logic [REM_W-1:0] FULL = REM_W'(NRANK * COPIES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(COPIES);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        PROBE,
        DEAL
    } state_t;

    state_t                          state_q, state_d;
    logic [WIDTH-1:0]                sr_q, sr_d;
    logic [3:0]                      rank_q, rank_d;
    logic [BIT_W-1:0]                bit_q, bit_d;
    logic [NRANK-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [REM_W-1:0]                remaining_q, remaining_d;
    logic [3:0]                      card_q, card_d;
    logic [3:0]                      value_q, value_d;
    logic                            valid_q, valid_d;
    logic                            busy_q, busy_d;
    logic                            empty_q, empty_d;

    // One step of MSB-first mod-13 reduction: shift in a bit, subtract 13 once if needed.
    logic [4:0] acc;
    logic [3:0] rank_step;
    always_comb begin
        acc       = {rank_q, sr_q[WIDTH-1]};
        rank_step = (acc >= 5'd13) ? 4'(acc - 5'd13) : acc[3:0];
    end

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            rank_q      <= '0;
            bit_q       <= '0;
            cnt_q       <= {NRANK{LOAD}};
            remaining_q <= FULL;
            card_q      <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            rank_q      <= rank_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            card_q      <= card_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            empty_q     <= empty_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        rank_d      = rank_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        card_d      = card_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        empty_d     = empty_q;

        case (state_q)
            IDLE: begin
                if (i_Shuffle) begin
                    cnt_d       = {NRANK{LOAD}};
                    remaining_d = FULL;
                    empty_d     = 1'b0;
                end else if (i_Draw && !empty_q) begin
                    sr_d    = i_Count;
                    rank_d  = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                sr_d   = sr_q << 1;
                rank_d = rank_step;
                bit_d  = BIT_W'(bit_q + 1'b1);
                if (bit_q == BIT_W'(WIDTH - 1)) begin
                    state_d = PROBE;
                end
            end
            PROBE: begin
                // Deck is non-empty, so this walk wraps around at most once.
                if (cnt_q[rank_q] != '0) begin
                    state_d = DEAL;
                end else begin
                    rank_d = (rank_q == 4'd12) ? 4'd0 : 4'(rank_q + 1'b1);
                end
            end
            DEAL: begin
                cnt_d[rank_q] = CNT_W'(cnt_q[rank_q] - 1'b1);
                remaining_d   = REM_W'(remaining_q - 1'b1);
                empty_d       = (remaining_q == REM_W'(1));
                card_d        = 4'(rank_q + 1'b1);
                value_d       = (rank_q >= 4'd9) ? 4'd10 : 4'(rank_q + 1'b1);
                valid_d       = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_Card      = card_q;
    assign o_Value     = value_q;
    assign o_Valid     = valid_q;
    assign o_Busy      = busy_q;
    assign o_Empty     = empty_q;
    assign o_Remaining = remaining_q;

endmodule
